// File: rtl/sa_out_collector.sv
// Receive end of the systolic-array result path: de-skews bottom-row SA outputs into
// aligned result rows and buffers them in a first-word-fall-through FIFO.
module sa_out_collector #(
  parameter int D_W        = 16,
  parameter int SA_C       = 16,
  parameter int LAT        = 17,
  parameter int MAX_M      = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(MAX_M+1)-1:0]    m,
  input  logic [SA_C-1:0][D_W-1:0]      sa_d,
  output logic [SA_C-1:0][D_W-1:0]      d,
  output logic                          valid,
  input  logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  input  logic                          clr_ovf
);

  localparam int MW       = $clog2(MAX_M+1);
  localparam int WAIT_END = LAT + SA_C - 2;
  localparam int CNT_MAX  = (WAIT_END > MAX_M) ? WAIT_END : MAX_M;
  localparam int CNT_W    = $clog2(CNT_MAX+1);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CAPT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [MW-1:0]      m_reg, m_next;
  logic               wr_en;

  logic [SA_C-1:0][D_W-1:0] aligned;

  // Column gi lags column 0 by gi cycles, so it needs SA_C-1-gi cycles of extra delay.
  genvar gi;
  generate
    for (gi = 0; gi < SA_C; gi++) begin : g_col
      localparam int L = SA_C - 1 - gi;
      if (L == 0) begin : g_pass
        assign aligned[gi] = sa_d[gi];
      end else begin : g_dly
        logic [D_W-1:0] dly_reg [0:L-1];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < L; k++) dly_reg[k] <= '0;
          end else begin
            dly_reg[0] <= sa_d[gi];
            for (int k = 1; k < L; k++) dly_reg[k] <= dly_reg[k-1];
          end
        end
        assign aligned[gi] = dly_reg[L-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      m_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      m_reg     <= m_next;
    end
  end

  // cnt equals the cycle index since start while waiting, so CAPT begins exactly when
  // row 0 is aligned at the delay outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    m_next     = m_reg;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && (m != '0)) begin
          state_next = ST_WAIT;
          cnt_next   = '0;
          m_next     = m;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == CNT_W'(WAIT_END)) begin
          state_next = ST_CAPT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_CAPT: begin
        wr_en = 1'b1;
        if (cnt_reg == CNT_W'(m_reg - MW'(1))) begin
          done       = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

  logic [SA_C-1:0][D_W-1:0] mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]            count_reg;
  logic                     ovf_reg;
  logic                     full, pop, push, ovf_set;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign valid   = (count_reg != '0);
  assign pop     = valid && ready;
  assign push    = wr_en && (!full || pop);
  assign ovf_set = wr_en && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= aligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
      if (ovf_set)      ovf_reg <= 1'b1;
      else if (clr_ovf) ovf_reg <= 1'b0;
    end
  end

  // Gating keeps the head at zero whenever the FIFO is empty, including right after reset.
  assign d   = valid ? mem[rd_ptr_reg] : '0;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_sa_out_collector.sv
// Directed bench for sa_out_collector: a cycle-indexed job/queue model is compared with
// the DUT every cycle, plus hand-computed literal checks for each scenario.
module tb_sa_out_collector;

  localparam int D_W   = 16;
  localparam int SA_C  = 4;
  localparam int LAT   = 3;
  localparam int MAX_M = 64;
  localparam int DEPTH = 4;
  localparam int MW    = $clog2(MAX_M+1);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [MW-1:0]            m = '0;
  logic [SA_C-1:0][D_W-1:0] sa_d = '0;
  logic [SA_C-1:0][D_W-1:0] d;
  logic                     valid;
  logic                     ready = 1'b0;
  logic                     busy;
  logic                     done;
  logic                     ovf;
  logic                     clr_ovf = 1'b0;

  int compared = 0;
  int mismatched = 0;

  sa_out_collector #(
    .D_W(D_W), .SA_C(SA_C), .LAT(LAT), .MAX_M(MAX_M), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .sa_d(sa_d), .d(d),
    .valid(valid), .ready(ready), .busy(busy), .done(done), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: job timing, sampled input history, row queue ----------------
  int                       cyc = 0;
  int                       job_s = -1000;
  int                       job_m = 0;
  logic [D_W-1:0]           job_base = '0;
  logic [D_W-1:0]           next_base = '0;
  logic [SA_C-1:0][D_W-1:0] hist [0:4095];
  logic [SA_C*D_W-1:0]      q [$];
  bit                       m_ovf = 0;

  function automatic bit mbusy(int c);
    return (job_m > 0) && (c >= job_s) && (c <= job_s + LAT + SA_C - 2 + job_m);
  endfunction

  always @(posedge clk) begin
    int r;
    bit pop, wr, full, drop;
    logic [SA_C-1:0][D_W-1:0] row;
    cyc++;
    hist[cyc-1] = sa_d;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      job_m = 0;
      job_s = -1000;
    end else begin
      pop = (q.size() != 0) && ready;
      wr  = 0;
      row = '0;
      if (job_m > 0) begin
        r = cyc - job_s - LAT - SA_C;
        if (r >= 0 && r < job_m) begin
          wr = 1;
          for (int j = 0; j < SA_C; j++) row[j] = hist[job_s + LAT + r + j][j];
        end
      end
      full = (q.size() == DEPTH);
      if (pop) void'(q.pop_front());
      drop = wr && full && !pop;
      if (wr && !drop) q.push_back(row);
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (start && m != '0 && !mbusy(cyc - 1)) begin
        job_s    = cyc;
        job_m    = int'(m);
        job_base = next_base;
      end
    end
  end

  // SA driver: row r of column j appears LAT+r+j cycles after the accepted start; junk otherwise.
  always @(posedge clk) begin
    int r;
    #1;
    for (int j = 0; j < SA_C; j++) begin
      r = cyc - job_s - LAT - j;
      if (job_m > 0 && r >= 0 && r < job_m)
        sa_d[j] = job_base + D_W'(16'h0100 * (r + 1) + j);
      else
        sa_d[j] = D_W'($urandom);
    end
  end

  always @(negedge clk) begin
    logic [SA_C*D_W-1:0] exp_d;
    if (rst_n && cyc > 0) begin
      exp_d = (q.size() != 0) ? q[0] : '0;
      chk("valid", valid, q.size() != 0);
      chk("d", d, exp_d);
      chk("busy", busy, mbusy(cyc));
      chk("done", done, (job_m > 0) && (cyc == job_s + LAT + SA_C - 2 + job_m));
      chk("ovf", ovf, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int mm);
    start = 1'b1;
    m     = MW'(mm);
    tick();
    start = 1'b0;
    m     = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && valid; i++) tick();
    chk("drain_timeout", valid, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_valid", valid, 1'b0);
    chk("rst_d", d, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 1: M=2, continuous ready
    ready = 1'b1;
    next_base = 16'h0000;
    do_start(2);
    repeat (6) tick();
    chk("t1_valid_c6", valid, 1'b0);
    tick();
    chk("t1_valid_c7", valid, 1'b1);
    chk("t1_row0", d, 64'h0103_0102_0101_0100);
    chk("t1_done_c7", done, 1'b1);
    tick();
    chk("t1_row1", d, 64'h0203_0202_0201_0200);
    wait_idle();
    wait_empty();

    // 2: M=4 into a stalled consumer fills the FIFO exactly
    ready = 1'b0;
    next_base = 16'h1000;
    do_start(4);
    wait_idle();
    chk("t2_ovf", ovf, 1'b0);
    repeat (3) tick();
    chk("t2_hold_row0", d, 64'h1103_1102_1101_1100);
    ready = 1'b1;
    wait_empty();

    // 3: M=6 overflows, ovf sticky until cleared
    ready = 1'b0;
    next_base = 16'h2000;
    do_start(6);
    wait_idle();
    repeat (2) tick();
    chk("t3_ovf_sticky", ovf, 1'b1);
    chk("t3_head_row0", d, 64'h2103_2102_2101_2100);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", ovf, 1'b0);
    ready = 1'b1;
    wait_empty();

    // 4: start during CAPT and start with M=0 are ignored
    next_base = 16'h3000;
    do_start(3);
    repeat (6) tick();
    chk("t4_busy_capt", busy, 1'b1);
    start = 1'b1;
    m = MW'(2);
    tick();
    start = 1'b0;
    m = '0;
    wait_idle();
    wait_empty();
    do_start(0);
    chk("t4_m0_ignored", busy, 1'b0);
    tick();

    // 6: full FIFO with simultaneous pop and write
    ready = 1'b0;
    next_base = 16'h4000;
    do_start(5);
    repeat (10) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t6_head_row1", d, 64'h4203_4202_4201_4200);
    chk("t6_ovf", ovf, 1'b0);
    wait_idle();
    ready = 1'b1;
    wait_empty();

    // 5: asynchronous reset mid-CAPT, then a fresh single-row job
    next_base = 16'h5000;
    do_start(4);
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", valid, 1'b0);
    chk("t5_rst_d", d, '0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_done", done, 1'b0);
    chk("t5_rst_ovf", ovf, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    ready = 1'b0;
    next_base = 16'h6000;
    do_start(1);
    repeat (7) tick();
    chk("t5_new_valid", valid, 1'b1);
    chk("t5_new_row0", d, 64'h6103_6102_6101_6100);
    ready = 1'b1;
    tick();
    chk("t5_single_row", valid, 1'b0);
    wait_idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
